// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode stage: opcodes, field positions and
// the decode FSM state encoding.
package isa_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_LDI  = 4'h6,
        OP_LDW  = 4'h7,
        OP_JMP  = 4'h8,
        OP_HALT = 4'hF
    } opcode_t;

    localparam int FIELD_W = 4;
    localparam int IMM8_W  = 8;
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 4;
    localparam int RS2_LSB = 0;

    typedef enum logic [1:0] {
        ST_DECODE,
        ST_EXT,
        ST_SQUASH,
        ST_HALT
    } state_t;

endpackage

// File: rtl/decode_fields.sv
// Pure field extraction for one instruction word; opcodes 9..E are flagged
// illegal, everything else is reported as-is.
module decode_fields
    import isa_pkg::*;
#(
    parameter int IW = 16
) (
    input  logic [IW-1:0]      instr,
    output logic [FIELD_W-1:0] op,
    output logic [FIELD_W-1:0] rd,
    output logic [FIELD_W-1:0] rs1,
    output logic [FIELD_W-1:0] rs2,
    output logic [IMM8_W-1:0]  imm8,
    output logic               illegal
);

    assign op      = instr[OP_LSB  +: FIELD_W];
    assign rd      = instr[RD_LSB  +: FIELD_W];
    assign rs1     = instr[RS1_LSB +: FIELD_W];
    assign rs2     = instr[RS2_LSB +: FIELD_W];
    assign imm8    = instr[0 +: IMM8_W];
    assign illegal = (op >= 4'h9) && (op <= 4'hE);

endmodule

// File: rtl/decode_unit.sv
// Decode stage: splits fetch words into fields, assembles two-word LDW,
// resolves JMP with a redirect plus wrong-path squash, and stops on HALT.
module decode_unit
    import isa_pkg::*;
#(
    parameter int AW = 8,
    parameter int IW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    input  logic [AW-1:0] in_pc,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_op,
    output logic [3:0]    out_rd,
    output logic [3:0]    out_rs1,
    output logic [3:0]    out_rs2,
    output logic [IW-1:0] out_imm,
    output logic [AW-1:0] out_pc,
    output logic          out_illegal,
    output logic          redirect_valid,
    output logic [AW-1:0] redirect_pc,
    output logic          halted
);

    logic [FIELD_W-1:0] f_op, f_rd, f_rs1, f_rs2;
    logic [IMM8_W-1:0]  f_imm8;
    logic               f_illegal;

    decode_fields #(.IW(IW)) u_fields (
        .instr   (in_instr),
        .op      (f_op),
        .rd      (f_rd),
        .rs1     (f_rs1),
        .rs2     (f_rs2),
        .imm8    (f_imm8),
        .illegal (f_illegal)
    );

    state_t          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [3:0]      out_op_q, out_op_d, out_rd_q, out_rd_d;
    logic [3:0]      out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
    logic [IW-1:0]   out_imm_q, out_imm_d;
    logic [AW-1:0]   out_pc_q, out_pc_d;
    logic            out_illegal_q, out_illegal_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [AW-1:0]   redirect_pc_q, redirect_pc_d;
    logic [3:0]      ldw_rd_q, ldw_rd_d;
    logic [AW-1:0]   ldw_pc_q, ldw_pc_d;
    logic            accept, do_decode;

    assign in_ready = !reset && !flush && (state_q != ST_HALT) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    // In SQUASH only the word at the jump target counts as a fresh decode.
    assign do_decode = accept && ((state_q == ST_DECODE) ||
                                  (state_q == ST_SQUASH && in_pc == redirect_pc_q));

    always_comb begin
        state_d          = state_q;
        out_valid_d      = out_valid_q;
        out_op_d         = out_op_q;
        out_rd_d         = out_rd_q;
        out_rs1_d        = out_rs1_q;
        out_rs2_d        = out_rs2_q;
        out_imm_d        = out_imm_q;
        out_pc_d         = out_pc_q;
        out_illegal_d    = out_illegal_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        ldw_rd_d         = ldw_rd_q;
        ldw_pc_d         = ldw_pc_q;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = ST_DECODE;
        end else if (accept && state_q == ST_EXT) begin
            out_valid_d   = 1'b1;
            out_op_d      = OP_LDW;
            out_rd_d      = ldw_rd_q;
            out_rs1_d     = 4'h0;
            out_rs2_d     = 4'h0;
            out_imm_d     = in_instr;
            out_pc_d      = ldw_pc_q;
            out_illegal_d = 1'b0;
            state_d       = ST_DECODE;
        end else if (do_decode) begin
            case (f_op)
                OP_LDW: begin
                    ldw_rd_d = f_rd;
                    ldw_pc_d = in_pc;
                    state_d  = ST_EXT;
                end
                OP_JMP: begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = AW'(f_imm8);
                    state_d          = ST_SQUASH;
                end
                default: begin
                    out_valid_d   = 1'b1;
                    out_op_d      = f_op;
                    out_rd_d      = f_rd;
                    out_rs1_d     = f_rs1;
                    out_rs2_d     = f_rs2;
                    out_imm_d     = (f_op == OP_LDI || f_illegal) ? IW'(f_imm8) : '0;
                    out_pc_d      = in_pc;
                    out_illegal_d = f_illegal;
                    state_d       = (f_op == OP_HALT) ? ST_HALT : ST_DECODE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_DECODE;
            out_valid_q      <= 1'b0;
            out_op_q         <= '0;
            out_rd_q         <= '0;
            out_rs1_q        <= '0;
            out_rs2_q        <= '0;
            out_imm_q        <= '0;
            out_pc_q         <= '0;
            out_illegal_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            ldw_rd_q         <= '0;
            ldw_pc_q         <= '0;
        end else begin
            state_q          <= state_d;
            out_valid_q      <= out_valid_d;
            out_op_q         <= out_op_d;
            out_rd_q         <= out_rd_d;
            out_rs1_q        <= out_rs1_d;
            out_rs2_q        <= out_rs2_d;
            out_imm_q        <= out_imm_d;
            out_pc_q         <= out_pc_d;
            out_illegal_q    <= out_illegal_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            ldw_rd_q         <= ldw_rd_d;
            ldw_pc_q         <= ldw_pc_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_op         = out_op_q;
    assign out_rd         = out_rd_q;
    assign out_rs1        = out_rs1_q;
    assign out_rs2        = out_rs2_q;
    assign out_imm        = out_imm_q;
    assign out_pc         = out_pc_q;
    assign out_illegal    = out_illegal_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign halted         = (state_q == ST_HALT);

endmodule
